// File: rtl/bist_pkg.sv
// rtl/bist_pkg.sv - shared states, LFSR/CRC step functions and parameter checks for bist_ctrl
package bist_pkg;

    localparam int STEP_W = 32;

    typedef enum logic [3:0] {
        IDLE,
        N_START,
        N_WAIT,
        N_OUT,
        T_SEED,
        T_SHIFT,
        T_START,
        T_WAIT,
        T_CRC,
        T_NEXT,
        T_DONE
    } bist_state_e;

    // Right-shifting Galois LFSR step; callers keep bits above their width at zero.
    function automatic logic [STEP_W-1:0] galois_step(input logic [STEP_W-1:0] s,
                                                      input logic [STEP_W-1:0] tap);
        return s[0] ? ((s >> 1) ^ tap) : (s >> 1);
    endfunction

    // One serial CRC shift of width w; poly excludes the implicit x^w term.
    function automatic logic [STEP_W-1:0] crc_step(input logic [STEP_W-1:0] crc,
                                                   input logic              din,
                                                   input logic [STEP_W-1:0] poly,
                                                   input int                w);
        logic [STEP_W-1:0] mask;
        logic [STEP_W-1:0] nxt;
        logic [4:0]        msb;
        mask = (w >= STEP_W) ? '1 : ((STEP_W'(1) << w) - STEP_W'(1));
        msb  = 5'(w - 1);
        nxt  = (crc << 1) & mask;
        if (crc[msb] ^ din) begin
            nxt = nxt ^ (poly & mask);
        end
        return nxt;
    endfunction

    // Display must hold the run counter above the signature.
    function automatic bit out_w_ok(input int out_w, input int crc_w);
        return out_w >= crc_w + 1;
    endfunction

    function automatic bit res_bits_ok(input int res_bits, input int res_w);
        return (res_bits >= 1) && (res_bits <= res_w);
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// rtl/bist_lfsr.sv - seedable Galois LFSR with zero-seed guard
module bist_lfsr
    import bist_pkg::*;
#(
    parameter int           W   = 8,
    parameter logic [W-1:0] TAP = 8'hB8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         seed_en,
    input  logic [W-1:0] seed,
    input  logic         shift_en,
    output logic [W-1:0] state
);

    // Seed load (zero would lock the LFSR, so it becomes 1) or single step.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= W'(1);
        end else if (seed_en) begin
            state <= (seed == '0) ? W'(1) : seed;
        end else if (shift_en) begin
            state <= W'(galois_step(STEP_W'(state), STEP_W'(TAP)));
        end
    end

endmodule

// File: rtl/bist_ctrl.sv
// rtl/bist_ctrl.sv - start/busy BIST controller with normal pass-through and CRC signature test
module bist_ctrl
    import bist_pkg::*;
#(
    parameter int               OP_W      = 8,
    parameter int               RES_W     = 24,
    parameter int               RES_BITS  = 12,
    parameter int               OUT_W     = 16,
    parameter int               CRC_W     = 8,
    parameter logic [CRC_W-1:0] CRC_POLY  = 8'h07,
    parameter logic [OP_W-1:0]  LFSR1_TAP = 8'hB8,
    parameter logic [OP_W-1:0]  LFSR2_TAP = 8'h8E,
    parameter int               N_ITER    = 256,
    parameter int               TIMEOUT   = 1023
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  a,
    input  logic [OP_W-1:0]  b,
    input  logic             test_req,
    input  logic [CRC_W-1:0] golden,
    output logic             dut_rst,
    output logic             dut_start,
    output logic [OP_W-1:0]  dut_a,
    output logic [OP_W-1:0]  dut_b,
    input  logic             dut_busy,
    input  logic [RES_W-1:0] dut_y,
    output logic [OUT_W-1:0] out,
    output logic             test_mode,
    output logic             done,
    output logic             pass,
    output logic             timeout
);

    localparam int RUN_W = OUT_W - CRC_W;
    localparam int BIT_W = $clog2(RES_BITS + 1);
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    if (!out_w_ok(OUT_W, CRC_W)) begin : g_chk_out_w
        $error("bist_ctrl: OUT_W must be at least CRC_W+1");
    end
    if (!res_bits_ok(RES_BITS, RES_W)) begin : g_chk_res_bits
        $error("bist_ctrl: RES_BITS must be within 1..RES_W");
    end

    bist_state_e      state_q, state_n;
    logic             pend_q, req_eff, abort, mode_exit, wd_hit;
    logic             seed_en, shift_en, iter_last, crc_last, first_q;
    logic [OP_W-1:0]  lfsr1, lfsr2;
    logic [CRC_W-1:0] crc_q;
    logic [15:0]      iter_q;
    logic [BIT_W-1:0] bit_q;
    logic [TO_W-1:0]  busy_cnt_q;
    logic [RES_W-1:0] res_q;
    logic [RUN_W-1:0] run_cnt_q;

    bist_lfsr #(.W(OP_W), .TAP(LFSR1_TAP)) u_lfsr1 (
        .clk(clk), .rst(rst), .seed_en(seed_en), .seed(a), .shift_en(shift_en), .state(lfsr1)
    );
    bist_lfsr #(.W(OP_W), .TAP(LFSR2_TAP)) u_lfsr2 (
        .clk(clk), .rst(rst), .seed_en(seed_en), .seed(b), .shift_en(shift_en), .state(lfsr2)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next state plus single-cycle strobes; a test_req inside a run aborts it.
    always_comb begin
        state_n   = state_q;
        req_eff   = pend_q ^ test_req;
        abort     = 1'b0;
        mode_exit = 1'b0;
        wd_hit    = 1'b0;
        seed_en   = 1'b0;
        shift_en  = 1'b0;
        iter_last = (iter_q == 16'(N_ITER - 1));
        crc_last  = (bit_q == BIT_W'(RES_BITS - 1));
        if (test_req && (state_q inside {T_SEED, T_SHIFT, T_START, T_WAIT, T_CRC, T_NEXT})) begin
            abort   = 1'b1;
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE:    state_n = (test_mode ^ req_eff) ? T_SEED : N_START;
                N_START: state_n = N_WAIT;
                N_WAIT:  if (!first_q && !dut_busy) state_n = N_OUT;
                N_OUT:   state_n = IDLE;
                T_SEED: begin
                    seed_en = 1'b1;
                    state_n = T_SHIFT;
                end
                T_SHIFT: begin
                    shift_en = 1'b1;
                    state_n  = T_START;
                end
                T_START: state_n = T_WAIT;
                T_WAIT: begin
                    if (!first_q) begin
                        if (!dut_busy) begin
                            state_n = T_CRC;
                        end else if (busy_cnt_q == TO_W'(TIMEOUT - 1)) begin
                            wd_hit  = 1'b1;
                            state_n = T_CRC;
                        end
                    end
                end
                T_CRC:   if (crc_last) state_n = T_NEXT;
                T_NEXT:  state_n = iter_last ? T_DONE : T_SHIFT;
                T_DONE: begin
                    if (req_eff) begin
                        mode_exit = 1'b1;
                        state_n   = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Datapath, DUT handshake, signature and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out        <= '0;
            test_mode  <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            dut_start  <= 1'b0;
            dut_a      <= '0;
            dut_b      <= '0;
            dut_rst    <= 1'b1;
            run_cnt_q  <= '0;
            pend_q     <= 1'b0;
            first_q    <= 1'b0;
            crc_q      <= '0;
            iter_q     <= '0;
            bit_q      <= '0;
            busy_cnt_q <= '0;
            res_q      <= '0;
        end else begin
            dut_rst   <= abort || mode_exit || (state_q == T_SHIFT);
            dut_start <= !abort && ((state_q == N_START) || (state_q == T_START));
            first_q   <= !abort && ((state_q == N_START) || (state_q == T_START));

            if (abort || mode_exit) begin
                test_mode <= 1'b0;
                pend_q    <= 1'b0;
            end else if (state_q == IDLE) begin
                test_mode <= test_mode ^ req_eff;
                pend_q    <= 1'b0;
            end else begin
                pend_q    <= req_eff;
            end

            if (state_q == N_START) begin
                dut_a <= a;
                dut_b <= b;
            end else if (state_q == T_START && !abort) begin
                dut_a <= lfsr1;
                dut_b <= lfsr2;
            end

            if (state_q == T_START) begin
                busy_cnt_q <= '0;
            end else if (state_q == T_WAIT && !first_q && dut_busy && !wd_hit) begin
                busy_cnt_q <= busy_cnt_q + TO_W'(1);
            end
            if (wd_hit) begin
                timeout <= 1'b1;
            end

            if (state_q == T_WAIT && state_n == T_CRC) begin
                res_q <= dut_y;
            end else if (state_q == T_CRC) begin
                res_q <= res_q >> 1;
            end
            bit_q <= (state_q == T_CRC) ? bit_q + BIT_W'(1) : '0;

            if (!abort) begin
                case (state_q)
                    N_OUT: out <= OUT_W'(dut_y);
                    T_SEED: begin
                        run_cnt_q <= run_cnt_q + RUN_W'(1);
                        out       <= {run_cnt_q + RUN_W'(1), {CRC_W{1'b0}}};
                        crc_q     <= '0;
                        iter_q    <= '0;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        timeout   <= 1'b0;
                    end
                    T_CRC: crc_q <= CRC_W'(crc_step(STEP_W'(crc_q), res_q[0], STEP_W'(CRC_POLY), CRC_W));
                    T_NEXT: begin
                        out[CRC_W-1:0] <= crc_q;
                        iter_q         <= iter_q + 16'd1;
                        if (iter_last) begin
                            done <= 1'b1;
                            pass <= (crc_q == golden) && !timeout;
                        end
                    end
                    T_DONE: begin
                        if (mode_exit) begin
                            done <= 1'b0;
                            pass <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bist_ctrl.sv
// tb/tb_bist_ctrl.sv - self-checking bench for bist_ctrl with behavioural DUT and signature model
module tb_bist_ctrl;

    localparam int N_ITER   = 4;
    localparam int TIMEOUT  = 15;
    localparam int RES_BITS = 12;
    localparam int M_MUL    = 0;
    localparam int M_ZERO   = 1;
    localparam int M_STUCK  = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  a = '0, b = '0, golden = '0;
    logic        test_req = 1'b0;
    logic        dut_rst, dut_start, test_mode, done, pass, timeout;
    logic [7:0]  dut_a, dut_b;
    logic [15:0] out;
    logic        dut_busy = 1'b0;
    logic [23:0] dut_y = '0;

    int checks = 0;
    int failures = 0;
    int dmode = M_MUL;
    int rem = 0;
    int exp_run = 0;
    int start_long = 0;
    bit start_prev = 1'b0;

    always #5 clk = ~clk;

    bist_ctrl #(
        .OP_W(8), .RES_W(24), .RES_BITS(RES_BITS), .OUT_W(16), .CRC_W(8),
        .CRC_POLY(8'h07), .LFSR1_TAP(8'hB8), .LFSR2_TAP(8'h8E),
        .N_ITER(N_ITER), .TIMEOUT(TIMEOUT)
    ) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .test_req(test_req), .golden(golden),
        .dut_rst(dut_rst), .dut_start(dut_start), .dut_a(dut_a), .dut_b(dut_b),
        .dut_busy(dut_busy), .dut_y(dut_y), .out(out), .test_mode(test_mode),
        .done(done), .pass(pass), .timeout(timeout)
    );

    // Behavioural start/busy DUT: y=a*b (or 0), random busy time, or busy stuck high.
    always @(posedge clk) begin
        if (dut_rst === 1'b1) begin
            dut_busy <= 1'b0;
            dut_y    <= '0;
            rem      <= 0;
        end else if (dut_start === 1'b1) begin
            dut_busy <= 1'b1;
            rem      <= int'($urandom_range(0, 3));
            dut_y    <= (dmode == M_ZERO) ? 24'h0 : 24'(16'(dut_a) * 16'(dut_b));
        end else if (dut_busy && dmode != M_STUCK) begin
            if (rem == 0) dut_busy <= 1'b0;
            else rem <= rem - 1;
        end
    end

    // Flags any dut_start high for two consecutive cycles.
    always @(negedge clk) begin
        if (dut_start === 1'b1 && start_prev) start_long = start_long + 1;
        start_prev = (dut_start === 1'b1);
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] s, input logic [7:0] tap);
        return s[0] ? ((s >> 1) ^ tap) : (s >> 1);
    endfunction

    // Whole-run signature from seeds: N_ITER LFSR pairs, RES_BITS LSBs each, CRC-8 poly 0x07.
    function automatic logic [7:0] ref_sig(input logic [7:0] sa, input logic [7:0] sb, input int mode);
        logic [7:0]  la, lb, crc;
        logic [23:0] y;
        bit          fb;
        la  = (sa == 8'h0) ? 8'h01 : sa;
        lb  = (sb == 8'h0) ? 8'h01 : sb;
        crc = 8'h00;
        for (int it = 0; it < N_ITER; it++) begin
            la = lfsr_next(la, 8'hB8);
            lb = lfsr_next(lb, 8'h8E);
            y  = (mode == M_ZERO) ? 24'h0 : 24'(16'(la) * 16'(lb));
            for (int k = 0; k < RES_BITS; k++) begin
                fb  = crc[7] ^ y[k];
                crc = {crc[6:0], 1'b0};
                if (fb) crc = crc ^ 8'h07;
            end
        end
        return crc;
    endfunction

    task automatic pulse_req();
        test_req = 1'b1;
        @(negedge clk);
        test_req = 1'b0;
    endtask

    task automatic wait_test_mode(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (test_mode === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_start(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dut_start === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin ok = 1'b1; break; end
        end
    endtask

    task automatic start_run(input logic [7:0] sa, input logic [7:0] sb, input logic [7:0] gold);
        bit ok;
        a = sa; b = sb; golden = gold;
        pulse_req();
        wait_test_mode(ok);
        exp_run = (exp_run + 1) % 256;
        checks++;
        if (!ok) begin failures++; $display("FAIL enter_test: test_mode=%b want 1", test_mode); end
    endtask

    task automatic finish_run(input logic [7:0] exp_sig, input logic exp_pass, input logic exp_to);
        bit ok;
        wait_done(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL run_done: done=%b want 1", done); end
        checks++;
        if (out[7:0] !== exp_sig) begin failures++; $display("FAIL run_signature: got %h want %h", out[7:0], exp_sig); end
        checks++;
        if (out[15:8] !== 8'(exp_run)) begin failures++; $display("FAIL run_count: got %0d want %0d", out[15:8], exp_run); end
        checks++;
        if (pass !== exp_pass) begin failures++; $display("FAIL run_pass: got %b want %b", pass, exp_pass); end
        checks++;
        if (timeout !== exp_to) begin failures++; $display("FAIL run_timeout: got %b want %b", timeout, exp_to); end
        dmode = M_MUL;
        pulse_req();
        checks++;
        if (test_mode !== 1'b0 || dut_rst !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL run_exit: test_mode=%b dut_rst=%b done=%b want 0/1/0", test_mode, dut_rst, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({out, dut_a, dut_b} !== 32'h0) begin failures++; $display("FAIL reset_data: got %h want 0", {out, dut_a, dut_b}); end
        checks++;
        if ({test_mode, done, pass, timeout, dut_start} !== 5'b0) begin
            failures++; $display("FAIL reset_flags: got %b want 00000", {test_mode, done, pass, timeout, dut_start});
        end
        checks++;
        if (dut_rst !== 1'b1) begin failures++; $display("FAIL reset_dut_rst: got %b want 1", dut_rst); end
        a = 8'd3; b = 8'd5;
        rst = 1'b0;
    endtask

    task automatic test_normal(input logic [7:0] ta, input logic [7:0] tb, input string name);
        logic [15:0] exp;
        bit          seen;
        exp  = 16'(ta) * 16'(tb);
        seen = 1'b0;
        a = ta; b = tb;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (out === exp && dut_a === ta && dut_b === tb) begin seen = 1'b1; break; end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL normal_%s: out=%h want %h", name, out, exp); end
    endtask

    task automatic test_lfsr_seed();
        bit ok;
        start_run(8'd2, 8'd2, ref_sig(8'd2, 8'd2, M_MUL));
        wait_start(ok);
        checks++;
        if (!ok || dut_a !== 8'h01 || dut_b !== 8'h01) begin
            failures++; $display("FAIL seed_first_ops: a=%h b=%h want 01/01", dut_a, dut_b);
        end
        checks++;
        if (out !== {8'(exp_run), 8'h00}) begin failures++; $display("FAIL seed_out: got %h want %h", out, {8'(exp_run), 8'h00}); end
        finish_run(ref_sig(8'd2, 8'd2, M_MUL), 1'b1, 1'b0);
    endtask

    task automatic test_zero_seed();
        bit ok;
        start_run(8'd0, 8'd7, ref_sig(8'd0, 8'd7, M_MUL) ^ 8'h01);
        wait_start(ok);
        checks++;
        if (!ok || dut_a !== 8'hB8 || dut_b !== lfsr_next(8'd7, 8'h8E)) begin
            failures++; $display("FAIL zero_seed_ops: a=%h b=%h want b8/%h", dut_a, dut_b, lfsr_next(8'd7, 8'h8E));
        end
        finish_run(ref_sig(8'd0, 8'd7, M_MUL), 1'b0, 1'b0);
    endtask

    task automatic test_random_runs();
        logic [7:0] sa, sb;
        for (int r = 0; r < 3; r++) begin
            sa = 8'($urandom_range(0, 255));
            sb = 8'($urandom_range(0, 255));
            start_run(sa, sb, ref_sig(sa, sb, M_MUL));
            finish_run(ref_sig(sa, sb, M_MUL), 1'b1, 1'b0);
        end
    endtask

    task automatic test_zero_dut();
        dmode = M_ZERO;
        start_run(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'h00);
        dmode = M_ZERO;
        finish_run(8'h00, 1'b1, 1'b0);
        dmode = M_ZERO;
        start_run(8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 8'h01);
        dmode = M_ZERO;
        finish_run(8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        bit         ok;
        logic [7:0] sa, sb;
        sa = 8'($urandom_range(0, 255));
        sb = 8'($urandom_range(0, 255));
        start_run(sa, sb, ref_sig(sa, sb, M_MUL));
        dmode = M_STUCK;
        wait_start(ok);
        repeat (TIMEOUT) @(negedge clk);
        checks++;
        if (!ok || timeout !== 1'b0) begin failures++; $display("FAIL timeout_early: got %b want 0", timeout); end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1) begin failures++; $display("FAIL timeout_set: got %b want 1", timeout); end
        dmode = M_STUCK;
        finish_run(ref_sig(sa, sb, M_STUCK), 1'b0, 1'b1);
    endtask

    task automatic test_abort();
        bit         ok;
        logic [7:0] sa;
        sa = 8'($urandom_range(0, 255));
        start_run(sa, 8'($urandom_range(0, 255)), 8'h00);
        ok = 1'b1;
        for (int s = 0; s < 3; s++) begin
            bit got;
            wait_start(got);
            ok = ok && got;
        end
        pulse_req();
        checks++;
        if (!ok || test_mode !== 1'b0 || dut_rst !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL abort_state: test_mode=%b dut_rst=%b done=%b want 0/1/0", test_mode, dut_rst, done);
        end
        @(negedge clk);
        checks++;
        if (dut_rst !== 1'b0) begin failures++; $display("FAIL abort_rst_width: got %b want 0", dut_rst); end
        @(negedge clk);
        checks++;
        if (dut_start !== 1'b1 || dut_a !== sa) begin
            failures++; $display("FAIL abort_resume: start=%b a=%h want 1/%h", dut_start, dut_a, sa);
        end
    endtask

    task automatic test_rst_mid_run();
        bit         ok;
        logic [7:0] sa, sb;
        start_run(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'h00);
        wait_start(ok);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (!ok || {out, dut_a, dut_b} !== 32'h0 || {test_mode, done, pass, timeout, dut_start} !== 5'b0 || dut_rst !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_run: out=%h a=%h b=%h flags=%b dut_rst=%b want all reset",
                     out, dut_a, dut_b, {test_mode, done, pass, timeout, dut_start}, dut_rst);
        end
        rst = 1'b0;
        exp_run = 0;
        sa = 8'($urandom_range(0, 255));
        sb = 8'($urandom_range(0, 255));
        start_run(sa, sb, ref_sig(sa, sb, M_MUL));
        finish_run(ref_sig(sa, sb, M_MUL), 1'b1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_normal(8'd3, 8'd5, "3x5");
        test_normal(8'd255, 8'd255, "255x255");
        for (int i = 0; i < 4; i++) begin
            test_normal(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), "random");
        end
        test_lfsr_seed();
        test_zero_seed();
        test_random_runs();
        test_zero_dut();
        test_timeout();
        test_abort();
        test_normal(8'd17, 8'd9, "after_abort");
        test_rst_mid_run();
        checks++;
        if (start_long !== 0) begin failures++; $display("FAIL start_single_pulse: long pulses=%0d want 0", start_long); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/bist_ctrl.md
Name: bist_ctrl

Overview:
- Parametrised built-in self-test controller for a start/busy handshake DUT (e.g. the `fun` datapath).
- Normal mode: continuously samples operands, runs the DUT and presents the result.
- Test mode: drives N_ITER pseudo-random operand pairs from two seeded Galois LFSRs and compresses RES_BITS result bits per iteration into a serial CRC. It then compares the signature against a golden value and reports pass/fail, with a busy-timeout watchdog.
- Sits between board I/O (switches, debounced button, display) and the DUT; the DUT is external, connected through the dut_* ports.

Parameters:
OP_W, 8, operand width (a, b, dut_a, dut_b, LFSRs)
RES_W, 24, DUT result width
RES_BITS, 12, result LSBs fed into the CRC per iteration (1..RES_W)
OUT_W, 16, display output width; must be >= CRC_W+1
CRC_W, 8, signature width
CRC_POLY, 8'h07, CRC polynomial (implicit x^CRC_W term)
LFSR1_TAP, 8'hB8, Galois tap mask for operand-a LFSR
LFSR2_TAP, 8'h8E, Galois tap mask for operand-b LFSR
N_ITER, 256, iterations per test run (1..65535)
TIMEOUT, 1023, maximum cycles dut_busy may stay high per operation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
a  in  OP_W  normal-mode operand a / LFSR1 seed
b  in  OP_W  normal-mode operand b / LFSR2 seed
test_req  in  1  mode-toggle request, single-cycle pulse (already debounced/edge-detected)
golden  in  CRC_W  expected signature
dut_rst  out  1  DUT reset
dut_start  out  1  DUT start pulse
dut_a  out  OP_W  DUT operand a
dut_b  out  OP_W  DUT operand b
dut_busy  in  1  DUT busy
dut_y  in  RES_W  DUT result
out  out  OUT_W  display value
test_mode  out  1  1 = test mode active
done  out  1  test run finished (held until next run or mode exit)
pass  out  1  valid when done: signature == golden and no timeout
timeout  out  1  sticky: a DUT operation exceeded TIMEOUT

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high.
- Reset values: out=0, test_mode=0, done=0, pass=0, timeout=0, dut_start=0, dut_a=0, dut_b=0, dut_rst=1, run_cnt=0, state=IDLE.
- Mode handling:
  - test_req toggles a pending flag. It is applied only in IDLE or T_DONE.
  - test_req received in any T_* state before T_DONE aborts the run: dut_rst=1 for one cycle, done/pass unchanged, go to IDLE with test_mode=0.
  - test_req during a normal operation takes effect at the next IDLE.
- FSM states:
  - IDLE: dut_rst=0. Go to T_SEED if test_mode, else N_START.
  - N_START: dut_a<=a, dut_b<=b, dut_start=1 for exactly one cycle, then N_WAIT.
  - N_WAIT: wait at least one cycle after start, until dut_busy=0, then N_OUT.
  - N_OUT: out<=dut_y[OUT_W-1:0] (zero-extend if RES_W<OUT_W), then IDLE.
  - T_SEED:
    - run_cnt++ (wraps); LFSR1<=a, LFSR2<=b; a zero seed is replaced by 1.
    - CRC<=0, iter<=0, done<=0, pass<=0, timeout<=0.
    - out[OUT_W-1:CRC_W] <= run_cnt (new value, truncated); out[CRC_W-1:0] <= 0.
  - T_SHIFT: both LFSRs advance once (s>>1, XOR TAP if s[0]=1); dut_rst=1 one cycle.
  - T_START: dut_a/dut_b <= LFSR states; dut_start one-cycle pulse.
  - T_WAIT:
    - Wait for dut_busy=0.
    - The watchdog counts busy cycles; reaching TIMEOUT sets timeout=1 and proceeds to T_CRC with dut_y as-is.
  - T_CRC:
    - Shift RES_BITS cycles, bit index 0 first: crc <= {crc<<1} ^ (CRC_POLY if crc[CRC_W-1]^bit).
    - Exactly RES_BITS shifts, no more, no less.
  - T_NEXT: out[CRC_W-1:0] <= crc. iter++. If iter==N_ITER-1 go to T_DONE, else T_SHIFT.
  - T_DONE:
    - done=1; pass = (crc==golden) && !timeout; out[CRC_W-1:0] = crc.
    - Hold while test_mode. On exit: dut_rst=1 one cycle, then IDLE.
- Latency:
  - Normal: operand sample to out update = 3 cycles + DUT busy time.
  - Test iteration: 3 + busy + RES_BITS + 1 cycles.
- rst has priority over test_req in the same cycle.

Decomposition:
- Package bist_pkg: state enum, galois_step and crc_step functions, and width checks on OUT_W and RES_BITS (elaboration error if violated).
- One sub-module, bist_lfsr (parametrised width/tap, seed/shift/zero-seed guard), instantiated twice.
- CRC stays inline.

Test Plan:
- Normal mode, DUT model y=a*b: a=3, b=5 -> dut_start single pulse, out=15 after busy falls; a=255, b=255 -> out=16'hFE01.
- Test mode, N_ITER=1, seed a=2, b=2 -> dut_a=dut_b=8'h01 at first start; seed a=0 -> dut_a=8'hB8 (zero-seed guard); out[15:8]=1.
- DUT model y=0, N_ITER=4, golden=0 -> signature 0, done=1, pass=1; golden=8'h01 -> pass=0.
- DUT model busy stuck high, TIMEOUT=15 -> timeout=1 after 15 busy cycles, run completes, pass=0.
- test_req mid-run (iteration 2 of 256) -> one-cycle dut_rst, IDLE, test_mode=0, next cycle resumes normal sampling.
- Second test run -> run_cnt=2 in out[15:8]; rst asserted mid-run -> all outputs at reset values next cycle.
